irq_axil_notifier: RTL



---
 rtl/irq_axil_notifier_if.sv | 42 ++++
 rtl/irq_axil_notifier.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_axil_notifier_if.sv
// AXI4-Lite bus bundle for irq_axil_notifier.
// master: the notifier issuing writes; slave: the host-side register target.
interface irq_axil_notifier_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/irq_axil_notifier.sv
// irq_axil_notifier: mirrors num_targets_p interrupt levels into per-target
// host registers with AXI4-Lite writes, round-robin between dirty targets,
// with bounded retry on error responses and a sticky drop flag.
// Optional feature macro: IRQ_AXIL_NOTIFIER_SYNC_EN adds a 2-flop
// synchroniser on irq_i (reset to 0); otherwise irq_i is used directly.
module irq_axil_notifier #(
    parameter int unsigned num_targets_p     = 2,
    parameter int unsigned axil_data_width_p = 32,
    parameter int unsigned axil_addr_width_p = 32,
    parameter logic [63:0] base_addr_p       = 64'h30_b000,
    parameter int unsigned stride_p          = 4,
    parameter int unsigned max_retries_p     = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [num_targets_p-1:0] irq_i,
    output logic                     busy_o,
    output logic                     err_o,
    irq_axil_notifier_if.master      m_axil
);

    localparam int unsigned TGT_W  = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;
    localparam int unsigned RTY_W  = (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1;
    localparam int unsigned STRB_W = axil_data_width_p / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [num_targets_p-1:0] w_irq_s;

`ifdef IRQ_AXIL_NOTIFIER_SYNC_EN
    logic [num_targets_p-1:0] r_sync1;
    logic [num_targets_p-1:0] r_sync2;

    // two-flop synchroniser for asynchronous interrupt lines
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_s = r_sync2;
`else
    assign w_irq_s = irq_i;
`endif

    state_t                   r_state,   w_state_n;
    logic [num_targets_p-1:0] r_sent,    w_sent_n;
    logic [TGT_W-1:0]         r_ptr,     w_ptr_n;
    logic [TGT_W-1:0]         r_tgt,     w_tgt_n;
    logic                     r_lvl,     w_lvl_n;
    logic [RTY_W-1:0]         r_retry,   w_retry_n;
    logic                     r_aw_done, w_aw_done_n;
    logic                     r_w_done,  w_w_done_n;
    logic                     r_awvalid, w_awvalid_n;
    logic                     r_wvalid,  w_wvalid_n;
    logic                     r_bready,  w_bready_n;
    logic [axil_addr_width_p-1:0] r_awaddr, w_awaddr_n;
    logic [axil_data_width_p-1:0] r_wdata,  w_wdata_n;
    logic [STRB_W-1:0]        r_wstrb,   w_wstrb_n;
    logic                     r_err,     w_err_n;

    logic [num_targets_p-1:0] w_dirty;
    logic                     w_found;
    logic [TGT_W-1:0]         w_pick;
    int unsigned              w_idx;
    logic [63:0]              w_addr_full;
    logic [TGT_W-1:0]         w_ptr_inc;
    logic                     w_aw_hs;
    logic                     w_w_hs;

    assign w_dirty   = w_irq_s ^ r_sent;
    assign w_aw_hs   = r_awvalid & m_axil.awready;
    assign w_w_hs    = r_wvalid & m_axil.wready;
    assign w_ptr_inc = (r_tgt == TGT_W'(num_targets_p - 1)) ? '0 : r_tgt + TGT_W'(1);

    // round-robin search for the first dirty target starting at r_ptr
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < num_targets_p; i++) begin
            w_idx = (32'(r_ptr) + i) % num_targets_p;
            if (!w_found && w_dirty[TGT_W'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = TGT_W'(w_idx);
            end
        end
        w_addr_full = base_addr_p + (64'(w_pick) * 64'(stride_p));
    end

    // state and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_sent    <= '0;
            r_ptr     <= '0;
            r_tgt     <= '0;
            r_lvl     <= 1'b0;
            r_retry   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_sent    <= w_sent_n;
            r_ptr     <= w_ptr_n;
            r_tgt     <= w_tgt_n;
            r_lvl     <= w_lvl_n;
            r_retry   <= w_retry_n;
            r_aw_done <= w_aw_done_n;
            r_w_done  <= w_w_done_n;
            r_awvalid <= w_awvalid_n;
            r_wvalid  <= w_wvalid_n;
            r_bready  <= w_bready_n;
            r_awaddr  <= w_awaddr_n;
            r_wdata   <= w_wdata_n;
            r_wstrb   <= w_wstrb_n;
            r_err     <= w_err_n;
        end
    end

    // next-state and next-output logic; valids/bready are computed one cycle
    // ahead so every bus output comes straight from a flop
    always_comb begin
        w_state_n   = r_state;
        w_sent_n    = r_sent;
        w_ptr_n     = r_ptr;
        w_tgt_n     = r_tgt;
        w_lvl_n     = r_lvl;
        w_retry_n   = r_retry;
        w_aw_done_n = r_aw_done;
        w_w_done_n  = r_w_done;
        w_awvalid_n = r_awvalid;
        w_wvalid_n  = r_wvalid;
        w_bready_n  = r_bready;
        w_awaddr_n  = r_awaddr;
        w_wdata_n   = r_wdata;
        w_wstrb_n   = r_wstrb;
        w_err_n     = r_err;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_tgt_n     = w_pick;
                    w_lvl_n     = w_irq_s[w_pick];
                    w_retry_n   = '0;
                    w_awaddr_n  = w_addr_full[axil_addr_width_p-1:0];
                    w_wdata_n   = axil_data_width_p'(w_irq_s[w_pick]);
                    w_wstrb_n   = '1;
                    w_aw_done_n = 1'b0;
                    w_w_done_n  = 1'b0;
                    w_awvalid_n = 1'b1;
                    w_wvalid_n  = 1'b1;
                    w_state_n   = SEND;
                end
            end
            SEND: begin
                if (w_aw_hs) begin
                    w_aw_done_n = 1'b1;
                    w_awvalid_n = 1'b0;
                end
                if (w_w_hs) begin
                    w_w_done_n = 1'b1;
                    w_wvalid_n = 1'b0;
                end
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                    w_aw_done_n = 1'b0;
                    w_w_done_n  = 1'b0;
                    w_bready_n  = 1'b1;
                    w_state_n   = RESP;
                end
            end
            RESP: begin
                if (m_axil.bvalid) begin
                    w_bready_n = 1'b0;
                    if (m_axil.bresp == 2'b00) begin
                        w_sent_n[r_tgt] = r_lvl;
                        w_ptr_n         = w_ptr_inc;
                        w_state_n       = IDLE;
                    end else if (r_retry < RTY_W'(max_retries_p)) begin
                        // address/data registers still hold the same payload
                        w_retry_n   = r_retry + RTY_W'(1);
                        w_awvalid_n = 1'b1;
                        w_wvalid_n  = 1'b1;
                        w_state_n   = SEND;
                    end else begin
                        // sent bit untouched: target stays dirty for a later turn
                        w_err_n   = 1'b1;
                        w_ptr_n   = w_ptr_inc;
                        w_state_n = IDLE;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign busy_o = (r_state != IDLE);
    assign err_o  = r_err;

    assign m_axil.awaddr  = r_awaddr;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;
    assign m_axil.araddr  = '0;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = 1'b0;
    assign m_axil.rready  = 1'b0;

endmodule
